multi_ff_reg: RTL and testbench
===============================

# multi_ff_reg

Parametrised multi-mode flip-flop register that generalises our single-bit D-to-T conversion to a WIDTH-bit bank. Under a registered mode select, every bit behaves as a D, T or JK flip-flop, or the whole bank acts as a synchronous T-chain up/down counter with a terminal-count pulse. It is the common storage/counting primitive for the flip-flop conversion series and for small control counters.

## Interface
- WIDTH, 8, number of flip-flops in the bank (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into Q on reset

- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- en  input  1  clock enable; 0 = hold all state
- mode  input  3  operation select (see Operation)
- d  input  WIDTH  D-mode data
- t  input  WIDTH  T-mode per-bit toggle enables
- j  input  WIDTH  JK-mode J inputs
- k  input  WIDTH  JK-mode K inputs
- Q  output  WIDTH  register state
- Qb  output  WIDTH  always ~Q
- tc  output  1  registered terminal-count pulse

## Operation
- Reset (rst_n=0 at a rising edge): Q=RESET_VAL, Qb=~RESET_VAL, tc=0. Reset overrides en and mode.
- en=0: Q holds, tc=0 on the next edge.
- mode (sampled only when en=1):
  - 000 HOLD: Q unchanged.
  - 001 D: Q ← d.
  - 010 T: Q ← Q ^ t (per-bit toggle).
  - 011 JK, per bit i: j=0,k=0 hold; j=0,k=1 clear; j=1,k=0 set; j=1,k=1 toggle.
  - 100 COUNT_UP: bit i toggles when bits 0..i-1 are all 1 and bit 0 always toggles (T-chain), i.e. Q ← Q+1 mod 2^WIDTH.
  - 101 COUNT_DN: bit i toggles when bits 0..i-1 are all 0, i.e. Q ← Q−1 mod 2^WIDTH.
  - 110, 111: reserved, treated as HOLD.
- tc is set to 1 for exactly one cycle on the edge where COUNT_UP wraps all-ones→0 or COUNT_DN wraps 0→all-ones. Otherwise tc=0.
- Qb is combinational ~Q and is never independently stored. Q and Qb are complementary in every cycle, including during reset.
- Mode changes take effect on the same edge they are sampled. There is no pipeline state between modes.

## Timing
- Single-cycle latency: inputs sampled at a rising edge appear on Q/Qb immediately after that edge.
- tc is registered in the same edge as the wrapping Q update, so it is aligned with Q=0 (up) or Q=all-ones (down).
- Reset asserted mid-count: the next edge forces RESET_VAL and tc=0. Counting resumes from RESET_VAL on the first edge with rst_n=1, en=1.
- WIDTH=1: COUNT_UP and COUNT_DN both toggle Q every enabled cycle, and tc fires on every wrap (every other cycle).
- There are no combinational paths from inputs to outputs except Q→Qb.

## Configuration
- MULTI_FF_COUNT_EN: when defined, modes 100/101 and tc behave as described.
- When MULTI_FF_COUNT_EN is undefined, modes 100/101 are treated as HOLD, tc is tied to 0, and the counter carry logic is not built. D, T and JK modes are unaffected.

## Test plan
- Reset: WIDTH=8, RESET_VAL=8'hA5, rst_n=0 for 2 edges → Q=8'hA5, Qb=8'h5A, tc=0. Mode and en are ignored during reset.
- T mode: start from Q=8'h00, mode=010, t=8'hFF for 2 cycles → Q=FF then 00. Then t=8'h01 for 3 cycles → Q=01,00,01. en=0 → Q holds.
- JK mode: start from Q=8'h0F, j=8'hF0, k=8'h3C → Q=8'hF3. Repeat with j=k=8'hFF → Q=8'h0C.
- COUNT_UP wrap: load d=8'hFE with mode 001, then mode 100 for 3 cycles → Q=FF, 00 (tc=1 in this cycle only), 01 (tc=0).
- COUNT_DN with mid-count reset: start from Q=8'h01, mode 101 → Q=00, then FF with tc=1. Assert rst_n=0 for one edge → Q=RESET_VAL, tc=0. Deassert → count resumes from RESET_VAL−1.
- Macro off: build without MULTI_FF_COUNT_EN, mode=100 for 4 cycles → Q unchanged, tc=0 throughout. Reserved mode 111 also holds Q in both builds.

Source files
------------

// File: rtl/multi_ff_reg.sv
// WIDTH-bit flip-flop bank: every bit acts as a D, T or JK flip-flop, or the bank is a T-chain up/down counter.
// Define MULTI_FF_COUNT_EN to build the counter modes (100/101) and the terminal-count pulse tc.
module multi_ff_reg #(
    parameter int unsigned       WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] t,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qb,
    output logic             tc
);

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'b000,
        MODE_D      = 3'b001,
        MODE_T      = 3'b010,
        MODE_JK     = 3'b011,
        MODE_CNT_UP = 3'b100,
        MODE_CNT_DN = 3'b101,
        MODE_RSV0   = 3'b110,
        MODE_RSV1   = 3'b111
    } mode_e;

    logic [WIDTH-1:0] q_q, q_d;
    logic             tc_q, tc_d;
    mode_e            mode_sel;

    assign mode_sel = mode_e'(mode);

`ifdef MULTI_FF_COUNT_EN
    logic [WIDTH-1:0] up_tog;
    logic [WIDTH-1:0] dn_tog;

    // T-chain toggle enables: bit i toggles when all lower bits are 1 (up) or 0 (down)
    always_comb begin : count_chain
        logic up_c;
        logic dn_c;
        up_c   = 1'b1;
        dn_c   = 1'b1;
        up_tog = '0;
        dn_tog = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            up_tog[i] = up_c;
            dn_tog[i] = dn_c;
            up_c      = up_c & q_q[i];
            dn_c      = dn_c & ~q_q[i];
        end
    end
`endif

    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        if (en) begin
            unique case (mode_sel)
                MODE_D:  q_d = d;
                MODE_T:  q_d = q_q ^ t;
                MODE_JK: q_d = (j & ~q_q) | (~k & q_q);
`ifdef MULTI_FF_COUNT_EN
                MODE_CNT_UP: begin
                    q_d  = q_q ^ up_tog;
                    tc_d = &q_q;
                end
                MODE_CNT_DN: begin
                    q_d  = q_q ^ dn_tog;
                    tc_d = ~|q_q;
                end
`endif
                default: q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_q  <= RESET_VAL;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    assign Q  = q_q;
    assign Qb = ~q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_multi_ff_reg.sv
// Directed bench for multi_ff_reg: arithmetic reference model checked every cycle, plus literal expectations.
module tb_multi_ff_reg;

    localparam int unsigned WIDTH = 8;
    localparam logic [WIDTH-1:0] RV = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n, en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] d, t, j, k;
    logic [WIDTH-1:0] Q, Qb;
    logic             tc;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    logic [WIDTH-1:0] m_q;
    logic             m_tc;

`ifdef MULTI_FF_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif

    multi_ff_reg #(.WIDTH(WIDTH), .RESET_VAL(RV)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode),
        .d(d), .t(t), .j(j), .k(k),
        .Q(Q), .Qb(Qb), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: next state from the mode rules using plain arithmetic
    always @(posedge clk) begin
        if (!rst_n) begin
            m_q  <= RV;
            m_tc <= 1'b0;
        end else if (!en) begin
            m_tc <= 1'b0;
        end else begin
            m_tc <= 1'b0;
            case (mode)
                3'b001: m_q <= d;
                3'b010: m_q <= m_q ^ t;
                3'b011: for (int i = 0; i < int'(WIDTH); i++)
                            m_q[i] <= (j[i] && k[i]) ? ~m_q[i] : (j[i] ? 1'b1 : (k[i] ? 1'b0 : m_q[i]));
                3'b100: if (CNT) begin
                            m_q  <= WIDTH'(m_q + 1);
                            m_tc <= (m_q == {WIDTH{1'b1}});
                        end
                3'b101: if (CNT) begin
                            m_q  <= WIDTH'(m_q - 1);
                            m_tc <= (m_q == '0);
                        end
                default: m_q <= m_q;
            endcase
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check("model_Q", Q, m_q);
            check("model_Qb", Qb, ~m_q);
            check("model_tc", WIDTH'(tc), WIDTH'(m_tc));
        end
    end

    // Apply one set of inputs, let one rising edge pass, then settle
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] tt,
                        input logic [WIDTH-1:0] jj, input logic [WIDTH-1:0] kk);
        rst_n = r; en = e; mode = m; d = dd; t = tt; j = jj; k = kk;
        @(posedge clk);
        #2;
    endtask

    task automatic lit(input string name, input logic [WIDTH-1:0] eq, input logic etc);
        check({name, "_Q"}, Q, eq);
        check({name, "_tc"}, WIDTH'(tc), WIDTH'(etc));
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; mode = 3'b001; d = 8'hFF; t = '0; j = '0; k = '0;
        @(posedge clk);
        #2;
        chk_on = 1'b1;
        step(1'b0, 1'b1, 3'b001, 8'hFF, 8'h00, 8'h00, 8'h00);
        lit("reset", 8'hA5, 1'b0);
        check("reset_Qb", Qb, 8'h5A);

        // T mode
        step(1'b1, 1'b1, 3'b001, 8'h00, 8'h00, 8'h00, 8'h00); lit("load00", 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'b010, 8'h00, 8'hFF, 8'h00, 8'h00); lit("t_ff_1", 8'hFF, 1'b0);
        step(1'b1, 1'b1, 3'b010, 8'h00, 8'hFF, 8'h00, 8'h00); lit("t_ff_2", 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'b010, 8'h00, 8'h01, 8'h00, 8'h00); lit("t_01_1", 8'h01, 1'b0);
        step(1'b1, 1'b1, 3'b010, 8'h00, 8'h01, 8'h00, 8'h00); lit("t_01_2", 8'h00, 1'b0);
        step(1'b1, 1'b1, 3'b010, 8'h00, 8'h01, 8'h00, 8'h00); lit("t_01_3", 8'h01, 1'b0);
        step(1'b1, 1'b0, 3'b010, 8'h00, 8'hFF, 8'h00, 8'h00); lit("en0_t", 8'h01, 1'b0);
        step(1'b1, 1'b0, 3'b001, 8'h77, 8'h00, 8'h00, 8'h00); lit("en0_d", 8'h01, 1'b0);

        // JK mode
        step(1'b1, 1'b1, 3'b001, 8'h0F, 8'h00, 8'h00, 8'h00); lit("load0f", 8'h0F, 1'b0);
        step(1'b1, 1'b1, 3'b011, 8'h00, 8'h00, 8'hF0, 8'h3C); lit("jk_mix", 8'hF3, 1'b0);
        step(1'b1, 1'b1, 3'b011, 8'h00, 8'h00, 8'hFF, 8'hFF); lit("jk_tog", 8'h0C, 1'b0);

        // Count up across the wrap
        step(1'b1, 1'b1, 3'b001, 8'hFE, 8'h00, 8'h00, 8'h00); lit("loadfe", 8'hFE, 1'b0);
        step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 8'h00); lit("up_1", CNT ? 8'hFF : 8'hFE, 1'b0);
        step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 8'h00); lit("up_2", CNT ? 8'h00 : 8'hFE, CNT);
        step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 8'h00); lit("up_3", CNT ? 8'h01 : 8'hFE, 1'b0);
        step(1'b1, 1'b1, 3'b100, 8'h00, 8'h00, 8'h00, 8'h00); lit("up_4", CNT ? 8'h02 : 8'hFE, 1'b0);

        // Count down across the wrap, then a mid-count reset
        step(1'b1, 1'b1, 3'b001, 8'h01, 8'h00, 8'h00, 8'h00); lit("load01", 8'h01, 1'b0);
        step(1'b1, 1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00); lit("dn_1", CNT ? 8'h00 : 8'h01, 1'b0);
        step(1'b1, 1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00); lit("dn_2", CNT ? 8'hFF : 8'h01, CNT);
        step(1'b0, 1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00); lit("dn_rst", 8'hA5, 1'b0);
        check("dn_rst_Qb", Qb, 8'h5A);
        step(1'b1, 1'b1, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00); lit("dn_resume", CNT ? 8'hA4 : 8'hA5, 1'b0);
        step(1'b1, 1'b0, 3'b101, 8'h00, 8'h00, 8'h00, 8'h00); lit("dn_en0", CNT ? 8'hA4 : 8'hA5, 1'b0);

        // Reserved modes hold
        step(1'b1, 1'b1, 3'b001, 8'h3C, 8'h00, 8'h00, 8'h00); lit("load3c", 8'h3C, 1'b0);
        step(1'b1, 1'b1, 3'b111, 8'hFF, 8'hFF, 8'hFF, 8'hFF); lit("rsv111_1", 8'h3C, 1'b0);
        step(1'b1, 1'b1, 3'b111, 8'hFF, 8'hFF, 8'hFF, 8'hFF); lit("rsv111_2", 8'h3C, 1'b0);
        step(1'b1, 1'b1, 3'b110, 8'hFF, 8'hFF, 8'hFF, 8'hFF); lit("rsv110", 8'h3C, 1'b0);
        step(1'b1, 1'b1, 3'b000, 8'hFF, 8'hFF, 8'hFF, 8'hFF); lit("hold000", 8'h3C, 1'b0);

        // Scattered pattern through each mode for the model
        for (int i = 0; i < 40; i++) begin
            step(1'b1, (i % 7) != 3, 3'(i % 8), 8'($urandom), 8'($urandom),
                 8'($urandom), 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
